// File: rtl/median_pkg.sv
// Shared definitions for the sliding rank-order filter: rank encodings,
// counter sizing and window-length legality.
package median_pkg;

   typedef enum logic [1:0] {
      RANK_MEDIAN = 2'd0,
      RANK_MIN    = 2'd1,
      RANK_MAX    = 2'd2,
      RANK_RSVD   = 2'd3
   } rank_e;

   function automatic int cnt_w(input int win);
      return $clog2(win + 1);
   endfunction

   function automatic bit win_ok(input int win);
      return (win % 2 == 1) && (win >= 3) && (win <= 15);
   endfunction

endpackage

// File: rtl/sorted_window_update.sv
// Combinational next-state of the sorted window: one delete (evicted value, or
// the free slot at fill_cnt while filling) followed by one ordered insert.
module sorted_window_update
   import median_pkg::*;
#(
   parameter int DATA_W = 4,
   parameter int WIN    = 5,
   parameter int CNT_W  = 3
) (
   input  logic [WIN*DATA_W-1:0] sorted_i,
   input  logic [DATA_W-1:0]     evict_i,
   input  logic [DATA_W-1:0]     new_i,
   input  logic                  full_i,
   input  logic [CNT_W-1:0]      fill_cnt_i,
   output logic [WIN*DATA_W-1:0] sorted_o
);

   function automatic logic cmp_le(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
      return a <= b;
   endfunction

   function automatic logic cmp_eq(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
      return a == b;
   endfunction

   logic [WIN-1:0][DATA_W-1:0] s;
   logic [WIN-1:0][DATA_W-1:0] n;
   logic [WIN-2:0][DATA_W-1:0] c;
   logic [WIN-2:0]             match;
   logic [WIN-2:0]             hit;
   logic [WIN-2:0]             le;

   // hit[i]: slot i lies at or above the deleted slot, so it takes its upper
   // neighbour. No hit below WIN-1 means the top slot is the one removed.
   always_comb begin
      s        = sorted_i;
      match    = '0;
      hit      = '0;
      c        = '0;
      le       = '0;
      n        = '0;
      for (int i = 0; i < WIN - 1; i++) begin
         match[i] = cmp_eq(s[i], evict_i);
      end
      hit[0] = full_i ? match[0] : (fill_cnt_i == '0);
      for (int i = 1; i < WIN - 1; i++) begin
         hit[i] = full_i ? (hit[i-1] | match[i]) : (CNT_W'(i) >= fill_cnt_i);
      end
      for (int i = 0; i < WIN - 1; i++) begin
         c[i]  = hit[i] ? s[i+1] : s[i];
         le[i] = (full_i || (CNT_W'(i) < fill_cnt_i)) && cmp_le(c[i], new_i);
      end
      // le is a prefix mask; the new value lands just past its last set bit
      n[0] = le[0] ? c[0] : new_i;
      for (int i = 1; i < WIN - 1; i++) begin
         n[i] = le[i] ? c[i] : (le[i-1] ? new_i : c[i-1]);
      end
      n[WIN-1] = le[WIN-2] ? new_i : c[WIN-2];
      sorted_o = n;
   end

endmodule

// File: rtl/sliding_median_filter.sv
// Streaming median/min/max over the last WIN accepted samples, with an
// age-ordered history, an incrementally maintained sorted array and one output register.
module sliding_median_filter
   import median_pkg::*;
#(
   parameter int DATA_W = 4,
   parameter int WIN    = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [1:0]        rank_sel,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
);

   localparam int CNT_W = cnt_w(WIN);
   localparam logic [CNT_W-1:0] WIN_C     = CNT_W'(WIN);
   localparam logic [CNT_W-1:0] LAST_FILL = CNT_W'(WIN - 1);

   generate
      if (!win_ok(WIN)) begin : g_bad_win
         $fatal(1, "sliding_median_filter: WIN must be odd and within 3..15");
      end
   endgenerate

   function automatic logic [DATA_W-1:0] pick_rank(input logic [WIN-1:0][DATA_W-1:0] s,
                                                    input logic [1:0] sel);
      case (rank_e'(sel))
         RANK_MIN: pick_rank = s[0];
         RANK_MAX: pick_rank = s[WIN-1];
         default:  pick_rank = s[(WIN-1)/2];
      endcase
   endfunction

   logic [CNT_W-1:0]           count_q, count_d;
   logic [WIN-1:0][DATA_W-1:0] hist_q, hist_d;
   logic [WIN-1:0][DATA_W-1:0] sorted_q, sorted_d;
   logic [WIN-1:0][DATA_W-1:0] sorted_upd;
   logic                       out_valid_q, out_valid_d;
   logic [DATA_W-1:0]          out_data_q, out_data_d;
   logic                       accept;
   logic                       full;

   assign in_ready  = !out_valid_q || out_ready;
   assign accept    = in_valid && in_ready;
   assign full      = (count_q == WIN_C);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

   // hist_q[WIN-1] is the oldest sample once the window is full
   sorted_window_update #(
      .DATA_W (DATA_W),
      .WIN    (WIN),
      .CNT_W  (CNT_W)
   ) u_sorted_update (
      .sorted_i   (sorted_q),
      .evict_i    (hist_q[WIN-1]),
      .new_i      (in_data),
      .full_i     (full),
      .fill_cnt_i (count_q),
      .sorted_o   (sorted_upd)
   );

   always_comb begin
      count_d     = count_q;
      hist_d      = hist_q;
      sorted_d    = sorted_q;
      out_valid_d = out_valid_q && !out_ready;
      out_data_d  = out_data_q;
      if (clear) begin
         count_d     = '0;
         out_valid_d = 1'b0;
      end else if (accept) begin
         hist_d   = {hist_q[WIN-2:0], in_data};
         sorted_d = sorted_upd;
         if (!full) begin
            count_d = count_q + 1'b1;
         end
         if (full || (count_q == LAST_FILL)) begin
            out_valid_d = 1'b1;
            out_data_d  = pick_rank(sorted_upd, rank_sel);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q     <= '0;
         hist_q      <= '0;
         sorted_q    <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         count_q     <= count_d;
         hist_q      <= hist_d;
         sorted_q    <= sorted_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

endmodule
